// File: rtl/product_accumulator.sv
// Accumulates a burst of 8-bit products into an ACC_W running sum with valid/ready handoff.
// Optional PRODUCT_ACCUMULATOR_SAT_EN: clamp to all-ones on overflow instead of wrapping.
module product_accumulator #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [7:0]       prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam logic [CNT_W:0] FULL = {1'b1, {CNT_W{1'b0}}};
    localparam logic [CNT_W:0] ONE  = {{CNT_W{1'b0}}, 1'b1};

    state_t           state;
    logic [CNT_W:0]   remaining;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] next_acc;
    logic             beat;

    assign prod_ready = (state == ACCUM);
    assign acc_valid  = (state == HOLD);
    assign busy       = (state != IDLE);
    assign beat       = prod_valid && prod_ready;

    // One extra bit so the carry-out flags overflow.
    assign sum = {1'b0, acc_out} + {{(ACC_W-7){1'b0}}, prod};

    always_comb begin
        next_acc = sum[ACC_W-1:0];
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
        if (sum[ACC_W] || ovf) begin
            next_acc = '1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            acc_out   <= '0;
            ovf       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= (len == '0) ? FULL : {1'b0, len};
                        acc_out   <= '0;
                        ovf       <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_out   <= next_acc;
                        remaining <= remaining - ONE;
                        if (sum[ACC_W]) begin
                            ovf <= 1'b1;
                        end
                        if (remaining == ONE) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (acc_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed-vector bench for product_accumulator.
// Expected values are hand-computed constants.
module tb_product_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  len;
    logic [7:0]  prod;
    logic        prod_valid;
    logic        prod_ready;
    logic [11:0] acc_out;
    logic        acc_valid;
    logic        acc_ready;
    logic        busy;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    product_accumulator #(.ACC_W(12), .CNT_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .len(len),
        .prod(prod),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .acc_out(acc_out),
        .acc_valid(acc_valid),
        .acc_ready(acc_ready),
        .busy(busy),
        .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++; if (acc_out !== 12'd0) begin bad++; $display("FAIL reset_acc got=%0d want=0", acc_out); end
        total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", acc_valid); end
        total++; if (prod_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", prod_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        prod_valid = 1'b1;
        prod = 8'd99;
        repeat (2) tick();
        prod_valid = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_ignore_busy got=%b want=0", busy); end
        total++; if (acc_out !== 12'd0) begin bad++; $display("FAIL idle_ignore_acc got=%0d want=0", acc_out); end
    endtask

    task automatic test_basic_burst();
        start = 1'b1;
        len = 5'd3;
        tick();
        start = 1'b0;
        total++; if (prod_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b want=1", prod_ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
        prod_valid = 1'b1;
        prod = 8'd225; tick();
        prod = 8'd1;   tick();
        total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", acc_valid); end
        prod = 8'd100; tick();
        prod_valid = 1'b0;
        total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", acc_valid); end
        total++; if (acc_out !== 12'd326) begin bad++; $display("FAIL basic_sum got=%0d want=326", acc_out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", ovf); end
        total++; if (prod_ready !== 1'b0) begin bad++; $display("FAIL basic_hold_ready got=%b want=0", prod_ready); end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL basic_handoff_valid got=%b want=0", acc_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_handoff_busy got=%b want=0", busy); end
        total++; if (acc_out !== 12'd326) begin bad++; $display("FAIL basic_keep_acc got=%0d want=326", acc_out); end
    endtask

    task automatic test_gaps_and_hold();
        logic [7:0] vals [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        int         run [4]  = '{10, 30, 60, 100};
        start = 1'b1;
        len = 5'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            prod_valid = 1'b1;
            prod = vals[i];
            tick();
            prod_valid = 1'b0;
            if (i < 3) begin
                prod = 8'd255;
                tick();
                total++; if (acc_out !== 12'(run[i])) begin bad++; $display("FAIL gap_hold_%0d got=%0d want=%0d", i, acc_out, run[i]); end
            end
        end
        for (int c = 0; c < 5; c++) begin
            total++; if (acc_out !== 12'd100) begin bad++; $display("FAIL hold_acc_%0d got=%0d want=100", c, acc_out); end
            total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL hold_valid_%0d got=%b want=1", c, acc_valid); end
            total++; if (prod_ready !== 1'b0) begin bad++; $display("FAIL hold_ready_%0d got=%b want=0", c, prod_ready); end
            tick();
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_release_busy got=%b want=0", busy); end
    endtask

    task automatic test_max_burst();
        logic [11:0] want;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
        want = 12'd4095;
`else
        want = 12'd3104;
`endif
        start = 1'b1;
        len = 5'd0;
        tick();
        start = 1'b0;
        prod_valid = 1'b1;
        prod = 8'd225;
        repeat (31) tick();
        total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL max_early_valid got=%b want=0", acc_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL max_busy got=%b want=1", busy); end
        tick();
        prod_valid = 1'b0;
        total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL max_valid got=%b want=1", acc_valid); end
        total++; if (acc_out !== want) begin bad++; $display("FAIL max_sum got=%0d want=%0d", acc_out, want); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL max_ovf got=%b want=1", ovf); end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL max_ovf_kept got=%b want=1", ovf); end
        start = 1'b1;
        len = 5'd1;
        tick();
        start = 1'b0;
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL restart_ovf got=%b want=0", ovf); end
        total++; if (acc_out !== 12'd0) begin bad++; $display("FAIL restart_acc got=%0d want=0", acc_out); end
        prod_valid = 1'b1;
        prod = 8'd0;
        tick();
        prod_valid = 1'b0;
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        len = 5'd5;
        tick();
        start = 1'b0;
        prod_valid = 1'b1;
        prod = 8'd50; tick();
        prod = 8'd60; tick();
        prod_valid = 1'b0;
        total++; if (acc_out !== 12'd110) begin bad++; $display("FAIL partial_acc got=%0d want=110", acc_out); end
        #2 rst = 1'b1;
        #1;
        total++; if (acc_out !== 12'd0) begin bad++; $display("FAIL async_acc got=%0d want=0", acc_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%b want=0", busy); end
        total++; if (prod_ready !== 1'b0) begin bad++; $display("FAIL async_ready got=%b want=0", prod_ready); end
        #1 rst = 1'b0;
        tick();
        start = 1'b1;
        len = 5'd1;
        tick();
        start = 1'b0;
        prod_valid = 1'b1;
        prod = 8'd7;
        tick();
        prod_valid = 1'b0;
        total++; if (acc_out !== 12'd7) begin bad++; $display("FAIL post_reset_acc got=%0d want=7", acc_out); end
        total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL post_reset_valid got=%b want=1", acc_valid); end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
    endtask

    task automatic test_start_ignored();
        start = 1'b1;
        len = 5'd2;
        tick();
        start = 1'b0;
        prod_valid = 1'b1;
        prod = 8'd5;
        start = 1'b1;
        len = 5'd7;
        tick();
        start = 1'b0;
        prod = 8'd6;
        tick();
        prod_valid = 1'b0;
        total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL accum_start_valid got=%b want=1", acc_valid); end
        total++; if (acc_out !== 12'd11) begin bad++; $display("FAIL accum_start_sum got=%0d want=11", acc_out); end
        start = 1'b1;
        acc_ready = 1'b1;
        tick();
        start = 1'b0;
        acc_ready = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_start_busy got=%b want=0", busy); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_start_nonew got=%b want=0", busy); end
        total++; if (acc_out !== 12'd11) begin bad++; $display("FAIL hold_start_acc got=%0d want=11", acc_out); end
        start = 1'b1;
        len = 5'd1;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy got=%b want=1", busy); end
        total++; if (acc_out !== 12'd0) begin bad++; $display("FAIL restart_clear got=%0d want=0", acc_out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL restart_ovf2 got=%b want=0", ovf); end
        prod_valid = 1'b1;
        prod = 8'd9;
        tick();
        prod_valid = 1'b0;
        total++; if (acc_out !== 12'd9) begin bad++; $display("FAIL final_sum got=%0d want=9", acc_out); end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        len = '0;
        prod = '0;
        prod_valid = 1'b0;
        acc_ready = 1'b0;
        #1;
        test_reset();
        test_basic_burst();
        test_gaps_and_hold();
        test_max_burst();
        test_async_reset();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 4x4 array multiplier's 8-bit product bus.
- Accumulates a programmed-length burst of products into a wide running sum, i.e. the accumulate half of a MAC, and hands the result to the next stage over a valid/ready handshake.
- Fully synchronous datapath; sits between the combinational multiplier output and the output/readback logic in the top wrapper.

Parameters:
- ACC_W, 12, accumulator and result width in bits (must be >= 8).
- CNT_W, 5, width of the burst-length field; burst holds 1..2^CNT_W products.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- len  input  CNT_W  burst length, latched on an accepted start; 0 encodes 2^CNT_W.
- prod  input  8  unsigned product from the multiplier.
- prod_valid  input  1  prod is valid this cycle.
- prod_ready  output  1  block accepts prod this cycle.
- acc_out  output  ACC_W  accumulated sum.
- acc_valid  output  1  acc_out holds a completed burst result.
- acc_ready  input  1  downstream accepts acc_out.
- busy  output  1  high in ACCUM or HOLD.
- ovf  output  1  sticky: the current burst exceeded 2^ACC_W-1.

Behaviour:
- Reset: state=IDLE, acc_out=0, acc_valid=0, prod_ready=0, busy=0, ovf=0, remaining count=0. Reset is asynchronous and takes effect mid-burst: any partial sum is discarded.
- All outputs come from registers or decode state only. There is no combinational path from inputs to outputs.
- IDLE:
  - prod_ready=0.
  - start=1 causes the following on the next edge: latch len (0 -> 2^CNT_W), clear acc_out and ovf, go to ACCUM.
  - prod_valid is ignored.
- ACCUM:
  - prod_ready=1.
  - A beat is prod_valid&&prod_ready. Each beat does acc_out <= acc_out + zero-extended prod and decrements the remaining count.
  - Cycles with no beat hold all state.
  - On the last beat (remaining==1), go to HOLD; acc_valid=1 from the next cycle. Latency from the last beat to acc_valid is 1 cycle.
  - start is ignored.
- HOLD:
  - prod_ready=0, acc_valid=1, acc_out stable.
  - acc_ready=1 causes the following on the next edge: acc_valid=0, go to IDLE.
  - start in the same cycle as acc_ready is ignored; it must be reasserted in IDLE.
- After handoff, acc_out and ovf keep their last values until the next accepted start.
- Arithmetic and overflow: the sum is computed at ACC_W+1 bits. If the carry bit is 1, ovf is set and stays set until the next start. The stored value is the low ACC_W bits, so it wraps modulo 2^ACC_W.
- Boundaries:
  - A len=1 burst completes after one beat.
  - The maximum burst of 2^CNT_W beats of 225 (7200) exceeds the default 4095 limit.
  - Back-to-back bursts: the minimum gap is 1 IDLE cycle between handoff and the next start.

Optional Feature:
- Macro: PRODUCT_ACCUMULATOR_SAT_EN.
- Defined: on carry-out the accumulator clamps to 2^ACC_W-1 and stays there for the rest of the burst; ovf is still set.
- Undefined: wrap-around as described above.
- Handshake and timing are identical in both builds.

Test Plan:
1. Assert rst for 3 cycles, then release -> acc_out=0, acc_valid=0, prod_ready=0, busy=0, ovf=0. Drive start=0 with prod_valid=1 -> no state change.
2. start with len=3; products 225, 1, 100 on consecutive cycles -> acc_out=326 and acc_valid=1 the cycle after the third beat, ovf=0. acc_ready=1 -> IDLE next cycle.
3. len=4; products 10, 20, 30, 40 with prod_valid=0 gaps between beats; hold acc_ready=0 for 5 cycles -> acc_out=100 stable, acc_valid held high, prod_ready=0 throughout HOLD.
4. len=0 (32 beats); every prod=225:
   - Wrap build: acc_out=3104 (7200 mod 4096), ovf=1.
   - PRODUCT_ACCUMULATOR_SAT_EN build: acc_out=4095, ovf=1.
5. len=5; accept 2 beats, then pulse rst asynchronously mid-cycle -> outputs return to reset values immediately. A fresh start with len=1 and prod=7 then gives acc_out=7.
6. Pulse start during ACCUM -> burst length unchanged. In HOLD, assert start together with acc_ready -> IDLE, no new burst. Assert start next cycle -> busy=1, acc_out=0, ovf cleared.
